// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and field constants for the instruction cache
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  localparam int TAG_MSB    = 9;
  localparam int TAG_LSB    = 7;
  localparam int IDX_MSB    = 6;
  localparam int IDX_LSB    = 4;
  localparam int WORD_MSB   = 3;
  localparam int WORD_LSB   = 2;
  localparam int BLOCK_BITS = 128;

  function automatic logic [31:0] word_sel(input logic [BLOCK_BITS-1:0] blk,
                                           input logic [31:0] w);
    return blk[w*32 +: 32];
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// rtl/instr_cache_if.sv - CPU fetch port and instruction-memory port of the cache
// master is the CPU/memory side, slave is the cache itself.
interface instr_cache_if import icache_pkg::*; ();

  logic [31:0]           PC;
  logic [31:0]           INSTRUCTION;
  logic                  BUSYWAIT;
  logic                  mem_read;
  logic [5:0]            mem_address;
  logic [BLOCK_BITS-1:0] mem_readdata;
  logic                  mem_busywait;

  modport master (
    output PC, mem_readdata, mem_busywait,
    input  INSTRUCTION, BUSYWAIT, mem_read, mem_address
  );

  modport slave (
    input  PC, mem_readdata, mem_busywait,
    output INSTRUCTION, BUSYWAIT, mem_read, mem_address
  );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage with combinational hit and word read
module icache_array import icache_pkg::*; #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 3,
  parameter int WORD_W   = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [TAG_W-1:0]      rd_tag,
  input  logic [WORD_W-1:0]     rd_word,
  output logic                  hit,
  output logic [31:0]           rd_instr,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [BLOCK_BITS-1:0] data_q [NUM_SETS];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset, but a reset edge must still suppress a pending fill.
  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_instr = word_sel(data_q[rd_idx], 32'(rd_word));

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache, refill FSM and memory handshake
module instr_cache import icache_pkg::*; #(
  parameter int ADDR_BITS       = 10,
  parameter int NUM_SETS        = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  instr_cache_if.slave  bus
);

  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int WORD_W  = $clog2(WORDS_PER_BLOCK);
  localparam int TAG_W   = ADDR_BITS - IDX_W - WORD_W - WORD_LSB;
  localparam int MADDR_W = TAG_W + IDX_W;

  state_t state_q, state_d;

  logic [MADDR_W-1:0]    miss_addr_q;
  logic [BLOCK_BITS-1:0] fill_buf_q;

  logic [WORD_W-1:0]  pc_word;
  logic [IDX_W-1:0]   pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic               hit;
  logic               wr_en;
  logic               mem_read;
  logic [MADDR_W-1:0] mem_address;
  logic               busywait;
  logic [31:0]        rd_instr;
  logic               unused_pc;

  assign pc_word   = bus.PC[WORD_LSB +: WORD_W];
  assign pc_idx    = bus.PC[WORD_LSB + WORD_W +: IDX_W];
  assign pc_tag    = bus.PC[WORD_LSB + WORD_W + IDX_W +: TAG_W];
  assign unused_pc = ^{bus.PC[31:ADDR_BITS], bus.PC[WORD_LSB-1:0]};

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .WORD_W   (WORD_W)
  ) u_array (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_idx   (pc_idx),
    .rd_tag   (pc_tag),
    .rd_word  (pc_word),
    .hit      (hit),
    .rd_instr (rd_instr),
    .wr_en    (wr_en),
    .wr_idx   (miss_addr_q[IDX_W-1:0]),
    .wr_tag   (miss_addr_q[MADDR_W-1:IDX_W]),
    .wr_data  (fill_buf_q)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      fill_buf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !hit) begin
        miss_addr_q <= {pc_tag, pc_idx};
      end
      if (state_q == MEM_READ && !bus.mem_busywait) begin
        fill_buf_q <= bus.mem_readdata;
      end
    end
  end

  // The refill works only from miss_addr_q, so PC may wander once the miss is latched.
  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_address = '0;
    busywait    = 1'b1;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        busywait = !hit;
        if (!hit) begin
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = miss_addr_q;
        if (!bus.mem_busywait) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_read    = mem_read;
  assign bus.mem_address = mem_address;
  assign bus.BUSYWAIT    = busywait;
  assign bus.INSTRUCTION = rd_instr;

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - self-checking bench for instr_cache against a set/tag reference model
module tb_instr_cache;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  instr_cache_if bus();

  instr_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic [127:0] mem_blocks [64];
  int lat    = 0;
  int rd_cnt = 0;

  // Memory holds busywait high for the first lat cycles of every read request.
  assign bus.mem_readdata = mem_blocks[bus.mem_address];
  assign bus.mem_busywait = bus.mem_read && (rd_cnt < lat);
  always @(posedge CLK) rd_cnt <= bus.mem_read ? rd_cnt + 1 : 0;

  int vectors = 0;
  int errors  = 0;
  bit ref_valid [8];
  int ref_tag   [8];

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    int blk = int'(pc % 1024) / 16;
    int w   = int'(pc % 16) / 4;
    return mem_blocks[blk][32*w +: 32];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int l, input string name);
    int idx = int'(pc % 128) / 16;
    int tag = int'(pc % 1024) / 128;
    int blk = int'(pc % 1024) / 16;
    bit exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    logic [31:0] exp_instr = mem_word(pc);
    int stalls = 0;
    int reads = 0;
    int bad_addr = 0;
    lat = l;
    bus.PC = pc;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.mem_read === 1'b1) begin
        reads++;
        if (bus.mem_address !== 6'(blk)) bad_addr++;
      end
      if (bus.BUSYWAIT === 1'b0) break;
      stalls++;
    end
    vectors++;
    if (stalls !== (exp_hit ? 0 : l + 3)) begin
      errors++;
      $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, exp_hit ? 0 : l + 3);
    end
    vectors++;
    if (reads !== (exp_hit ? 0 : l + 1)) begin
      errors++;
      $display("FAIL %s mem_read cycles: got %0d expected %0d", name, reads, exp_hit ? 0 : l + 1);
    end
    vectors++;
    if (bad_addr !== 0) begin
      errors++;
      $display("FAIL %s mem_address: got %0d wrong cycles expected 0 (addr 0x%02h)", name, bad_addr, blk);
    end
    vectors++;
    if (bus.INSTRUCTION !== exp_instr) begin
      errors++;
      $display("FAIL %s instruction: got 0x%08h expected 0x%08h", name, bus.INSTRUCTION, exp_instr);
    end
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tag;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET  = 1'b1;
    bus.PC = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (bus.mem_read !== 1'b0 || bus.mem_address !== 6'h0) begin
      errors++;
      $display("FAIL reset outputs: got mem_read=%b addr=0x%02h expected 0/0x00", bus.mem_read, bus.mem_address);
    end
    RESET = 1'b0;
    clear_model();
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h000, 5, "cold_miss");
  endtask

  task automatic test_seq_hits();
    do_fetch(32'h004, 5, "seq_hit_4");
    do_fetch(32'h008, 5, "seq_hit_8");
    do_fetch(32'h00C, 5, "seq_hit_c");
  endtask

  task automatic test_conflict();
    do_fetch(32'h080, 4, "conflict_080");
    do_fetch(32'h000, 4, "conflict_000");
  endtask

  task automatic test_zero_latency();
    do_fetch(32'h3FC, 0, "zero_lat_3fc");
  endtask

  task automatic test_reset_mid_refill();
    lat    = 5;
    bus.PC = 32'h080;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    vectors++;
    if (bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre-reset mem_read: got %b expected 1", bus.mem_read);
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET  = 1'b0;
    bus.PC = 32'h000;
    clear_model();
    #3;
    vectors++;
    if (bus.mem_read !== 1'b0 || bus.mem_address !== 6'h0 || bus.BUSYWAIT !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid after reset: got mem_read=%b addr=0x%02h busy=%b expected 0/0x00/1",
               bus.mem_read, bus.mem_address, bus.BUSYWAIT);
    end
    do_fetch(32'h000, 5, "reset_mid_refetch");
  endtask

  task automatic test_pc_wander();
    logic [5:0] addrs[$];
    int stalls = 0;
    bit addr_ok;
    lat    = 3;
    bus.PC = 32'h010;
    @(posedge CLK);
    #1;
    bus.PC = 32'h020;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.mem_read === 1'b1) addrs.push_back(bus.mem_address);
      if (bus.BUSYWAIT === 1'b0) break;
      stalls++;
    end
    addr_ok = (addrs.size() == 8);
    for (int i = 0; i < addrs.size(); i++)
      if (addrs[i] !== ((i < 4) ? 6'h01 : 6'h02)) addr_ok = 1'b0;
    vectors++;
    if (!addr_ok) begin
      errors++;
      $display("FAIL pc_wander addresses: got %0d reads (first 0x%02h) expected 4x0x01 then 4x0x02",
               addrs.size(), (addrs.size() > 0) ? addrs[0] : 6'h0);
    end
    vectors++;
    if (stalls !== 11) begin
      errors++;
      $display("FAIL pc_wander stall cycles: got %0d expected 11", stalls);
    end
    vectors++;
    if (bus.INSTRUCTION !== mem_word(32'h020)) begin
      errors++;
      $display("FAIL pc_wander instruction: got 0x%08h expected 0x%08h", bus.INSTRUCTION, mem_word(32'h020));
    end
    ref_valid[1] = 1'b1; ref_tag[1] = 0;
    ref_valid[2] = 1'b1; ref_tag[2] = 0;
    @(posedge CLK);
    #1;
    do_fetch(32'h014, 3, "pc_wander_set1_hit");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int blk = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
      logic [31:0] pc = ($urandom & 32'hFFFF_FC00) | 32'(blk * 16)
                        | 32'($urandom_range(0, 3) * 4) | 32'($urandom_range(0, 3));
      do_fetch(pc, $urandom_range(0, 4), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_blocks[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_blocks[0] = {32'h44, 32'h33, 32'h22, 32'h11};
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_zero_latency();
    test_reset_mid_refill();
    test_pc_wander();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
